// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D interface: FSM states, command layout and widths.
package a2d_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RES_W      = 12;
  localparam int CH_LSB     = 11;
  localparam int CH_MSB     = 13;

  typedef enum logic [2:0] {
    IDLE,
    FRAME1,
    GAP,
    FRAME2,
    DONE
  } a2d_state_e;

  // Command word: channel in bits 13:11, every other bit zero.
  function automatic logic [FRAME_BITS-1:0] chnl_cmd(input logic [2:0] ch);
    logic [FRAME_BITS-1:0] c;
    c = '0;
    c[CH_MSB:CH_LSB] = ch;
    return c;
  endfunction

endpackage

// File: rtl/spi_mstr16.sv
// Generic 16-bit SPI mode-3 master: MISO sampled on SCLK rise, MOSI shifted on SCLK fall.
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W  = 5,
  parameter int FRONT_PORCH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrt,
  input  logic [FRAME_BITS-1:0] cmd,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rd_data,
  output logic                  SS_n,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  // Idle/load value keeps the divider MSB set so SCLK idles high (FRONT_PORCH <= half period).
  localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = SCLK_DIV_W'((1 << SCLK_DIV_W) - FRONT_PORCH);
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;

  logic [SCLK_DIV_W-1:0] sclk_div;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;
  logic                  all_bits;
  logic                  rise;
  logic                  shift;

  assign all_bits = (bit_cnt == CNT_W'(FRAME_BITS));
  assign rise     = !SS_n && (sclk_div == DIV_RISE);
  // The first fall after SS_n drops must not shift: the MSB is already on MOSI.
  assign shift    = !SS_n && (sclk_div == DIV_FALL) && (bit_cnt != '0) && !all_bits;
  assign done     = !SS_n && (sclk_div == DIV_FALL) && all_bits;

  assign SCLK    = sclk_div[SCLK_DIV_W-1];
  assign MOSI    = tx_sr[FRAME_BITS-1];
  assign rd_data = rx_sr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n     <= 1'b1;
      sclk_div <= DIV_LOAD;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else if (SS_n) begin
      if (wrt) begin
        SS_n     <= 1'b0;
        sclk_div <= DIV_LOAD;
        bit_cnt  <= '0;
        tx_sr    <= cmd;
      end
    end else if (done) begin
      SS_n     <= 1'b1;
      sclk_div <= DIV_LOAD;
      tx_sr    <= '0;
    end else begin
      sclk_div <= sclk_div + SCLK_DIV_W'(1);
      if (rise) begin
        rx_sr   <= {rx_sr[FRAME_BITS-2:0], MISO};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (shift) tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// Two-frame A2D conversion sequencer: address frame, 2-clk gap, result frame.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W  = 5,
  parameter int FRONT_PORCH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt_cnv,
  input  logic [2:0]       chnnl,
  output logic             cnv_cmplt,
  output logic [RES_W-1:0] res,
  output logic             SS_n,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO
);

  a2d_state_e            state, nxt_state;
  logic                  gap_cnt;
  logic [2:0]            ch_q;
  logic                  wrt_q, wrt_nxt;
  logic                  ld_ch, set_cmplt;
  logic                  done;
  logic [FRAME_BITS-1:0] rd_data;
  logic                  unused_rd_hi;

  assign unused_rd_hi = ^rd_data[FRAME_BITS-1:RES_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= 1'b0;
      ch_q      <= '0;
      wrt_q     <= 1'b0;
      cnv_cmplt <= 1'b0;
      res       <= '0;
    end else begin
      state   <= nxt_state;
      wrt_q   <= wrt_nxt;
      gap_cnt <= (state == GAP) && !gap_cnt;
      if (ld_ch) begin
        ch_q      <= chnnl;
        cnv_cmplt <= 1'b0;
      end
      if (set_cmplt) begin
        cnv_cmplt <= 1'b1;
        res       <= rd_data[RES_W-1:0];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_state = state;
    wrt_nxt   = 1'b0;
    ld_ch     = 1'b0;
    set_cmplt = 1'b0;
    case (state)
      IDLE: if (strt_cnv) begin
        ld_ch     = 1'b1;
        wrt_nxt   = 1'b1;
        nxt_state = FRAME1;
      end
      FRAME1: if (done) nxt_state = GAP;
      // wrt is registered, so it is raised in the first gap cycle to drop SS_n as the gap ends.
      GAP: begin
        if (gap_cnt) nxt_state = FRAME2;
        else         wrt_nxt   = 1'b1;
      end
      FRAME2: if (done) nxt_state = DONE;
      DONE: begin
        set_cmplt = 1'b1;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  spi_mstr16 #(
    .SCLK_DIV_W (SCLK_DIV_W),
    .FRONT_PORCH(FRONT_PORCH)
  ) u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrt    (wrt_q),
    .cmd    (chnl_cmd(ch_q)),
    .done   (done),
    .rd_data(rd_data),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO)
  );

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a mode-3 ADC model and SPI edge-discipline monitor.
module tb_a2d_intf;

  logic        clk;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int n_checks;
  int n_fail;

  a2d_intf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: frame 1 returns filler, frame 2 returns the table entry for the channel addressed in frame 1.
  logic [15:0] adc_tbl [8];
  logic [15:0] last_cmd [2];
  logic [15:0] resp;
  logic [15:0] mosi_sr;
  logic [2:0]  cmd_ch;
  logic        frame_par;
  logic        prev_ss, prev_sclk, prev_mosi;
  logic        miso_q;
  int          falls;
  int          ss_hi;
  int          ss_falls;
  int          gap_seen;
  int          gap_bad;
  int          mosi_viol;

  assign MISO = miso_q;

  initial begin
    for (int i = 0; i < 8; i++) adc_tbl[i] = 16'h0000;
    adc_tbl[5] = 16'h0ABC;
    adc_tbl[0] = 16'hF123;
    adc_tbl[2] = 16'h7456;
    adc_tbl[6] = 16'h0789;
    last_cmd[0] = 16'hxxxx;
    last_cmd[1] = 16'hxxxx;
    ss_falls  = 0;
    gap_seen  = 0;
    gap_bad   = 0;
    mosi_viol = 0;
    cmd_ch    = 3'd0;
    mosi_sr   = 16'h0000;
    resp      = 16'h0000;
    falls     = 0;
    ss_hi     = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      frame_par = 1'b0;
      prev_ss   = 1'b1;
      prev_sclk = 1'b1;
      prev_mosi = 1'b0;
      miso_q    = 1'b0;
      ss_hi     = 0;
    end else begin
      if (prev_ss && !SS_n) begin
        ss_falls++;
        if (frame_par) begin
          gap_seen++;
          if (ss_hi != 2) gap_bad++;
        end
        resp    = frame_par ? adc_tbl[cmd_ch] : 16'hA5A5;
        miso_q  = resp[15];
        falls   = 0;
        mosi_sr = 16'h0000;
      end else if (!SS_n) begin
        if (prev_sclk && !SCLK) begin
          if (falls != 0) begin
            resp   = {resp[14:0], 1'b0};
            miso_q = resp[15];
          end
          falls++;
        end
        if (!prev_sclk && SCLK) begin
          mosi_sr = {mosi_sr[14:0], MOSI};
          if (MOSI !== prev_mosi) mosi_viol++;
        end
      end
      if (!prev_ss && SS_n) begin
        last_cmd[frame_par] = mosi_sr;
        if (!frame_par) cmd_ch = mosi_sr[13:11];
        frame_par = ~frame_par;
      end
      if (SS_n) ss_hi = prev_ss ? ss_hi + 1 : 1;
      prev_ss   = SS_n;
      prev_sclk = SCLK;
      prev_mosi = MOSI;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_strt(input logic [2:0] ch);
    @(negedge clk);
    chnnl    = ch;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
  endtask

  // Counts clk edges after the accepting edge until cnv_cmplt is seen high (bounded).
  task automatic wait_cmplt(output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cnv_cmplt) break;
    end
  endtask

  int cyc;
  int f0;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    strt_cnv = 1'b0;
    chnnl    = 3'd0;

    // Reset held with strt_cnv toggling: no SPI activity.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      strt_cnv = ~strt_cnv;
      chnnl    = 3'(k);
      check("rst_ss_n", 32'(SS_n), 32'd1);
      check("rst_sclk", 32'(SCLK), 32'd1);
    end
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_cmplt", 32'(cnv_cmplt), 32'd0);
    check("rst_res", 32'(res), 32'h000);
    @(negedge clk);
    strt_cnv = 1'b0;
    rst_n    = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_ss_n", 32'(SS_n), 32'd1);
    check("idle_no_frames", 32'(ss_falls), 32'd0);

    // Basic conversion, channel 5.
    pulse_strt(3'd5);
    check("basic_cmplt_low", 32'(cnv_cmplt), 32'd0);
    wait_cmplt(cyc);
    check("basic_latency", 32'(cyc), 32'd1044);
    check("basic_res", 32'(res), 32'hABC);
    check("basic_mosi_f1", 32'(last_cmd[0]), 32'h2800);
    check("basic_mosi_f2", 32'(last_cmd[1]), 32'h2800);

    // Back-to-back: request one clk after cnv_cmplt rises, channel 0.
    chnnl    = 3'd0;
    strt_cnv = 1'b1;
    @(posedge clk);
    #1;
    strt_cnv = 1'b0;
    check("b2b_cmplt_fall", 32'(cnv_cmplt), 32'd0);
    check("b2b_res_hold", 32'(res), 32'hABC);
    wait_cmplt(cyc);
    check("b2b_latency", 32'(cyc), 32'd1044);
    check("b2b_res", 32'(res), 32'h123);
    check("b2b_mosi_f1", 32'(last_cmd[0]), 32'h0000);

    // Busy: requests during FRAME2 and coincident with DONE are both ignored.
    f0 = ss_falls;
    pulse_strt(3'd2);
    for (int k = 1; k <= 1043; k++) begin
      @(negedge clk);
      if (k == 700) begin
        chnnl    = 3'd6;
        strt_cnv = 1'b1;
      end else if (k == 1043) begin
        chnnl    = 3'd6;
        strt_cnv = 1'b1;
      end else begin
        strt_cnv = 1'b0;
      end
    end
    @(negedge clk);
    strt_cnv = 1'b0;
    check("busy_cmplt", 32'(cnv_cmplt), 32'd1);
    check("busy_res", 32'(res), 32'h456);
    repeat (600) @(negedge clk);
    check("busy_cmplt_hold", 32'(cnv_cmplt), 32'd1);
    check("busy_ss_idle", 32'(SS_n), 32'd1);
    check("busy_frames", 32'(ss_falls - f0), 32'd2);
    check("busy_mosi_f2", 32'(last_cmd[1]), 32'h1000);

    // Mid-frame reset during bit 7 of frame 1.
    pulse_strt(3'd3);
    repeat (250) @(negedge clk);
    check("mid_in_frame", 32'(SS_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_ss_n", 32'(SS_n), 32'd1);
    check("mid_sclk", 32'(SCLK), 32'd1);
    check("mid_cmplt", 32'(cnv_cmplt), 32'd0);
    check("mid_res", 32'(res), 32'h000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_strt(3'd6);
    wait_cmplt(cyc);
    check("post_rst_latency", 32'(cyc), 32'd1044);
    check("post_rst_res", 32'(res), 32'h789);
    check("post_rst_mosi_f1", 32'(last_cmd[0]), 32'h3000);

    // Edge discipline over the whole run.
    repeat (4) @(negedge clk);
    check("mosi_stable_at_rise", 32'(mosi_viol), 32'd0);
    check("gap_count", 32'(gap_seen), 32'd4);
    check("gap_len_bad", 32'(gap_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
